// File: rtl/r_bram_addr_gen_pkg.sv
// ---------------------------------------------------------------------------
// r_bram_addr_gen_pkg
// Shared definitions for the BRAM port-B read-address generator and its
// companion write-side generator.
//   ADDR_WIDTH      : system address width; port-B word address is ADDR_WIDTH-2
//   RB_MODE_ONESHOT : run a single pass, then return to IDLE with a done pulse
//   RB_MODE_CIRC    : restart from base at the end of every pass (wrap pulse)
//   rb_state_t      : generator FSM states (RB_IDLE, RB_RUN)
// ---------------------------------------------------------------------------
package r_bram_addr_gen_pkg;

  localparam int ADDR_WIDTH = 11;

  localparam logic RB_MODE_ONESHOT = 1'b0;
  localparam logic RB_MODE_CIRC    = 1'b1;

  typedef enum logic {
    RB_IDLE = 1'b0,
    RB_RUN  = 1'b1
  } rb_state_t;

endpackage

// File: rtl/r_bram_addr_gen_if.sv
// ---------------------------------------------------------------------------
// r_bram_addr_gen_if
// Bundles the configuration, control handshake and address outputs between
// the read-side controller (master) and the address generator (slave).
//   cfg_base, cfg_len, cfg_stride, cfg_mode : pass configuration
//   start, adv, abort                       : control from the controller
//   ADDR_B, busy, last, done, wrap          : generator status / address
//   rd_valid, rd_last                       : read-data qualifiers, present
//                                             only with R_BRAM_ADDR_RVALID_EN
// ---------------------------------------------------------------------------
interface r_bram_addr_gen_if
  import r_bram_addr_gen_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH - 2
);

  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W:0]   cfg_len;
  logic [ADDR_W-1:0] cfg_stride;
  logic              cfg_mode;
  logic              start;
  logic              adv;
  logic              abort;

  logic [ADDR_W-1:0] ADDR_B;
  logic              busy;
  logic              last;
  logic              done;
  logic              wrap;
`ifdef R_BRAM_ADDR_RVALID_EN
  logic              rd_valid;
  logic              rd_last;
`endif

  modport master (
    output cfg_base, cfg_len, cfg_stride, cfg_mode, start, adv, abort,
    input  ADDR_B, busy, last, done, wrap
`ifdef R_BRAM_ADDR_RVALID_EN
    , input rd_valid, rd_last
`endif
  );

  modport slave (
    input  cfg_base, cfg_len, cfg_stride, cfg_mode, start, adv, abort,
    output ADDR_B, busy, last, done, wrap
`ifdef R_BRAM_ADDR_RVALID_EN
    , output rd_valid, rd_last
`endif
  );

endinterface

// File: rtl/r_bram_addr_wrap_add.sv
// ---------------------------------------------------------------------------
// r_bram_addr_wrap_add
// Combinational modulo-DEPTH adder used to step BRAM addresses.
//   a, b : operands, each must be < DEPTH
//   sum  : (a + b) mod DEPTH
// The sum is formed one bit wider than the address so the carry is visible;
// because both operands are < DEPTH a single conditional subtract suffices.
// ---------------------------------------------------------------------------
module r_bram_addr_wrap_add #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] b,
  output logic [ADDR_W-1:0] sum
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    if (raw >= DEPTH_V) begin
      sum = ADDR_W'(raw - DEPTH_V);
    end else begin
      sum = raw[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/r_bram_addr_gen.sv
// ---------------------------------------------------------------------------
// r_bram_addr_gen
// BRAM port-B read-address generator with programmable base, length and
// stride, one-shot or circular passes, start/busy/done handshake and abort.
// base=0, len=0, stride=1, CIRCULAR reproduces a free-running 0..DEPTH-1
// counter.
//   CLK  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : r_bram_addr_gen_if.slave (cfg_*, start, adv, abort in;
//          ADDR_B, busy, last, done, wrap out)
// Optional build macro: R_BRAM_ADDR_RVALID_EN adds bus.rd_valid / bus.rd_last,
// the issued-read and final-read flags delayed RD_LAT cycles to line up with
// BRAM dout.
// ---------------------------------------------------------------------------
module r_bram_addr_gen
  import r_bram_addr_gen_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH - 2,
  parameter int DEPTH  = 512
`ifdef R_BRAM_ADDR_RVALID_EN
  , parameter int RD_LAT = 1
`endif
) (
  input  logic             CLK,
  input  logic             rst,
  r_bram_addr_gen_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  rb_state_t         state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              wrap_reg;

  // Configuration captured on an accepted start; cfg_* is ignored in RUN.
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] stride_reg;
  logic              mode_reg;
  logic [ADDR_W:0]   len_m1_reg;

  logic [ADDR_W:0]   len_m1_next;
  logic [ADDR_W-1:0] addr_step;
  logic              last_w;

  // Zero and out-of-range lengths both mean a full-depth pass.
  always_comb begin
    if (bus.cfg_len == '0 || bus.cfg_len > DEPTH_V) begin
      len_m1_next = DEPTH_V - LEN_ONE;
    end else begin
      len_m1_next = bus.cfg_len - LEN_ONE;
    end
  end

  r_bram_addr_wrap_add #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_wrap_add (
    .a   (addr_reg),
    .b   (stride_reg),
    .sum (addr_step)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg  <= RB_IDLE;
      addr_reg   <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
      base_reg   <= '0;
      stride_reg <= '0;
      mode_reg   <= RB_MODE_ONESHOT;
      len_m1_reg <= '0;
    end else begin
      // done/wrap are single-cycle pulses.
      done_reg <= 1'b0;
      wrap_reg <= 1'b0;
      case (state_reg)
        RB_IDLE: begin
          if (bus.start && !bus.abort) begin
            base_reg   <= bus.cfg_base;
            stride_reg <= bus.cfg_stride;
            mode_reg   <= bus.cfg_mode;
            len_m1_reg <= len_m1_next;
            addr_reg   <= bus.cfg_base;
            cnt_reg    <= len_m1_next;
            busy_reg   <= 1'b1;
            state_reg  <= RB_RUN;
          end
        end
        RB_RUN: begin
          if (bus.abort) begin
            // Address is held so the controller can see where it stopped.
            busy_reg  <= 1'b0;
            state_reg <= RB_IDLE;
          end else if (bus.adv) begin
            if (cnt_reg == '0) begin
              if (mode_reg == RB_MODE_ONESHOT) begin
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= RB_IDLE;
              end else begin
                addr_reg <= base_reg;
                cnt_reg  <= len_m1_reg;
                wrap_reg <= 1'b1;
              end
            end else begin
              addr_reg <= addr_step;
              cnt_reg  <= cnt_reg - LEN_ONE;
            end
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= RB_IDLE;
        end
      endcase
    end
  end

  assign last_w     = busy_reg && (cnt_reg == '0);

  assign bus.ADDR_B = addr_reg;
  assign bus.busy   = busy_reg;
  assign bus.last   = last_w;
  assign bus.done   = done_reg;
  assign bus.wrap   = wrap_reg;

`ifdef R_BRAM_ADDR_RVALID_EN
  // Reads issued before an abort still return data, so abort only gates new
  // issues and never clears the delay line.
  logic              rv_in;
  logic              rl_in;
  logic [RD_LAT-1:0] rv_pipe_reg;
  logic [RD_LAT-1:0] rl_pipe_reg;

  assign rv_in = busy_reg && bus.adv && !bus.abort;
  assign rl_in = last_w && bus.adv && !bus.abort;

  always_ff @(posedge CLK) begin
    if (rst) begin
      rv_pipe_reg <= '0;
      rl_pipe_reg <= '0;
    end else begin
      rv_pipe_reg[0] <= rv_in;
      rl_pipe_reg[0] <= rl_in;
      for (int i = 1; i < RD_LAT; i++) begin
        rv_pipe_reg[i] <= rv_pipe_reg[i-1];
        rl_pipe_reg[i] <= rl_pipe_reg[i-1];
      end
    end
  end

  assign bus.rd_valid = rv_pipe_reg[RD_LAT-1];
  assign bus.rd_last  = rl_pipe_reg[RD_LAT-1];
`endif

endmodule

// File: tb/tb_r_bram_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_r_bram_addr_gen
// Self-checking bench for r_bram_addr_gen (DEPTH=512, ADDR_W=9, RD_LAT=1).
// A behavioural model predicts the outputs for every driven cycle; the
// prediction is queued and compared against the DUT one clock later.
// Scenario-specific literal checks complement the model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_r_bram_addr_gen;
  import r_bram_addr_gen_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              last;
    logic              done;
    logic              wrap;
    logic              rv;
    logic              rl;
  } exp_t;

  logic CLK = 1'b0;
  logic rst = 1'b1;

  r_bram_addr_gen_if #(.ADDR_W(ADDR_W)) bus ();

  r_bram_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";
  exp_t  sb_q[$];

  // Behavioural model state
  int m_addr = 0, m_cnt = 0, m_lenm1 = 0, m_base = 0, m_stride = 0;
  bit m_busy = 0, m_done = 0, m_wrap = 0, m_mode = 0, m_rv = 0, m_rl = 0;

  // Observed pulse counters, cleared per scenario
  int wrap_seen = 0;
  int done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, expv);
    end
  endtask

  task automatic model_step(input bit st, input bit ad, input bit ab, input bit rs);
    bit iss, lst;
    int len;
    iss = m_busy && ad && !ab;
    lst = m_busy && (m_cnt == 0) && ad && !ab;
    if (rs) begin
      m_addr = 0; m_cnt = 0; m_busy = 0; m_done = 0; m_wrap = 0;
      m_rv = 0; m_rl = 0;
    end else begin
      m_done = 0; m_wrap = 0;
      m_rv = iss; m_rl = lst;
      if (!m_busy) begin
        if (st && !ab) begin
          len = int'(bus.cfg_len);
          if (len == 0 || len > DEPTH) len = DEPTH;
          m_lenm1  = len - 1;
          m_base   = int'(bus.cfg_base);
          m_stride = int'(bus.cfg_stride);
          m_mode   = bus.cfg_mode;
          m_addr   = m_base;
          m_cnt    = m_lenm1;
          m_busy   = 1;
        end
      end else if (ab) begin
        m_busy = 0;
      end else if (ad) begin
        if (m_cnt == 0) begin
          if (m_mode == RB_MODE_ONESHOT) begin
            m_busy = 0; m_done = 1;
          end else begin
            m_addr = m_base; m_cnt = m_lenm1; m_wrap = 1;
          end
        end else begin
          m_addr = (m_addr + m_stride) % DEPTH;
          m_cnt  = m_cnt - 1;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, queue the prediction, then compare.
  task automatic cyc(input bit st, input bit ad, input bit ab, input bit rs);
    exp_t e;
    bus.start = st; bus.adv = ad; bus.abort = ab; rst = rs;
    model_step(st, ad, ab, rs);
    e.addr = ADDR_W'(m_addr);
    e.busy = m_busy;
    e.last = m_busy && (m_cnt == 0);
    e.done = m_done;
    e.wrap = m_wrap;
    e.rv   = m_rv;
    e.rl   = m_rl;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check("addr", 32'(bus.ADDR_B), 32'(e.addr));
    check("busy", 32'(bus.busy), 32'(e.busy));
    check("last", 32'(bus.last), 32'(e.last));
    check("done", 32'(bus.done), 32'(e.done));
    check("wrap", 32'(bus.wrap), 32'(e.wrap));
`ifdef R_BRAM_ADDR_RVALID_EN
    check("rd_valid", 32'(bus.rd_valid), 32'(e.rv));
    check("rd_last", 32'(bus.rd_last), 32'(e.rl));
`endif
    if (bus.wrap === 1'b1) wrap_seen++;
    if (bus.done === 1'b1) done_seen++;
  endtask

  task automatic set_cfg(input int base, input int len, input int stride, input bit mode);
    bus.cfg_base   = ADDR_W'(base);
    bus.cfg_len    = (ADDR_W + 1)'(len);
    bus.cfg_stride = ADDR_W'(stride);
    bus.cfg_mode   = mode;
  endtask

  task automatic new_phase(input string name);
    phase = name;
    wrap_seen = 0;
    done_seen = 0;
  endtask

  int os_seq[5] = '{500, 507, 2, 9, 16};

  initial begin
    bus.start = 0; bus.adv = 0; bus.abort = 0;
    set_cfg(0, 0, 1, RB_MODE_CIRC);

    // Reset state
    new_phase("reset");
    repeat (3) cyc(0, 0, 0, 1);
    check("addr0", 32'(bus.ADDR_B), 0);
    check("busy0", 32'(bus.busy), 0);
    cyc(0, 1, 0, 0);   // adv in IDLE is ignored
    $display("txn reset: addr=%0d busy=%0d", bus.ADDR_B, bus.busy);

    // Legacy free-running counter
    new_phase("legacy");
    set_cfg(0, 0, 1, RB_MODE_CIRC);
    cyc(1, 0, 0, 0);
    check("first", 32'(bus.ADDR_B), 0);
    for (int i = 1; i <= 1030; i++) begin
      cyc(0, 1, 0, 0);
      check("seq", 32'(bus.ADDR_B), 32'(i % DEPTH));
    end
    check("wrap_count", 32'(wrap_seen), 2);
    check("done_count", 32'(done_seen), 0);
    cyc(0, 0, 1, 0);
    $display("txn legacy: 1030 advs, wraps=%0d dones=%0d", wrap_seen, done_seen);

    // ONESHOT with stride crossing the top of memory
    new_phase("oneshot");
    set_cfg(500, 5, 7, RB_MODE_ONESHOT);
    cyc(1, 0, 0, 0);
    check("seq0", 32'(bus.ADDR_B), 32'(os_seq[0]));
    for (int k = 1; k < 5; k++) begin
      cyc(0, 1, 0, 0);
      check("seq", 32'(bus.ADDR_B), 32'(os_seq[k]));
    end
    check("last16", 32'(bus.last), 1);
    cyc(0, 1, 0, 0);
    check("done", 32'(bus.done), 1);
    check("busy_fall", 32'(bus.busy), 0);
    check("hold", 32'(bus.ADDR_B), 16);
    cyc(0, 0, 0, 0);
    check("done_pulse", 32'(bus.done), 0);
    $display("txn oneshot: base=500 len=5 stride=7 end_addr=%0d", bus.ADDR_B);

    // Gapped adv
    new_phase("gapped");
    set_cfg(10, 3, 1, RB_MODE_ONESHOT);
    cyc(1, 0, 0, 0);
    for (int j = 0; j < 6; j++) cyc(0, bit'(j % 2), 0, 0);
    check("done_count", 32'(done_seen), 1);
    check("end_addr", 32'(bus.ADDR_B), 12);
    $display("txn gapped: dones=%0d addr=%0d", done_seen, bus.ADDR_B);

    // Abort mid-run, cfg changes during RUN ignored, then re-latch
    new_phase("abort");
    set_cfg(12, 8, 1, RB_MODE_CIRC);
    cyc(1, 0, 0, 0);
    set_cfg(100, 2, 5, RB_MODE_ONESHOT);
    cyc(0, 0, 0, 0);
    check("cfg_ignored", 32'(bus.ADDR_B), 12);
    cyc(0, 1, 1, 0);
    check("busy", 32'(bus.busy), 0);
    check("addr_hold", 32'(bus.ADDR_B), 12);
    check("no_done", 32'(bus.done), 0);
    cyc(1, 0, 0, 0);
    check("relatch", 32'(bus.ADDR_B), 100);
    cyc(0, 1, 0, 0);
    check("stride5", 32'(bus.ADDR_B), 105);
    cyc(0, 1, 0, 0);
    check("done", 32'(bus.done), 1);
    $display("txn abort: relatched base=100 done=%0d", bus.done);

    // Reset mid-run, then start together with abort in IDLE
    new_phase("rst_mid");
    set_cfg(0, 10, 1, RB_MODE_CIRC);
    cyc(1, 0, 0, 0);
    repeat (6) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    check("addr", 32'(bus.ADDR_B), 0);
    check("busy", 32'(bus.busy), 0);
    check("done", 32'(bus.done), 0);
    cyc(1, 0, 1, 0);
    check("start_abort", 32'(bus.busy), 0);
    $display("txn rst_mid: addr=%0d busy=%0d", bus.ADDR_B, bus.busy);

    // len=1 then back-to-back stride=0 pass
    new_phase("len1");
    set_cfg(7, 1, 3, RB_MODE_ONESHOT);
    cyc(1, 0, 0, 0);
    check("last_now", 32'(bus.last), 1);
    cyc(0, 1, 0, 0);
    check("done", 32'(bus.done), 1);
    new_phase("stride0");
    set_cfg(99, 4, 0, RB_MODE_ONESHOT);
    cyc(1, 0, 0, 0);   // start in the done cycle
    check("b2b_addr", 32'(bus.ADDR_B), 99);
    check("b2b_busy", 32'(bus.busy), 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 0);
      check("const", 32'(bus.ADDR_B), 99);
    end
    check("done_count", 32'(done_seen), 1);
    $display("txn stride0: addr=%0d dones=%0d", bus.ADDR_B, done_seen);

    // Over-range length behaves as full depth
    new_phase("len_big");
    set_cfg(0, 600, 1, RB_MODE_CIRC);
    cyc(1, 0, 0, 0);
    repeat (511) cyc(0, 1, 0, 0);
    check("last511", 32'(bus.last), 1);
    cyc(0, 1, 0, 0);
    check("wrap", 32'(bus.wrap), 1);
    cyc(0, 0, 1, 0);
    $display("txn len_big: wraps=%0d", wrap_seen);

    new_phase("end");
    check("sb_empty", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/r_bram_addr_gen.md
Name: r_bram_addr_gen

Overview:
Parametrised BRAM read-address generator for port B. It replaces the fixed 0..511 free-running counter. It adds a programmable base, length and stride; one-shot or circular modes; a start/busy/done handshake; and abort. It sits between the read-side controller, which issues start and adv, and the BRAM port B address input. Setting base=0, len=0 (full depth), stride=1 and mode=CIRCULAR reproduces the legacy counter exactly.

Parameters:
ADDR_W, 9 (`ADDR_WIDTH-2`), width of ADDR_B.
DEPTH, 512, number of addressable words. Must satisfy DEPTH <= 2**ADDR_W.
RD_LAT, 1, BRAM read latency in cycles. Used only with R_BRAM_ADDR_RVALID_EN.

Ports:
CLK  in  1  clock. All logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
cfg_base  in  ADDR_W  first address. Must be < DEPTH.
cfg_len  in  ADDR_W+1  reads per pass. A value of 0 means DEPTH. Values > DEPTH are treated as DEPTH.
cfg_stride  in  ADDR_W  address increment. Must be < DEPTH. A value of 0 repeats the same address.
cfg_mode  in  1  0 = ONESHOT, 1 = CIRCULAR.
start  in  1  begin a pass. Sampled only in IDLE.
adv  in  1  consume the current address and advance.
abort  in  1  terminate the run.
ADDR_B  out  ADDR_W  BRAM port B address (registered).
busy  out  1  high in RUN.
last  out  1  high when ADDR_B is the final address of the pass (busy && cnt==0). Combinational.
done  out  1  one-cycle pulse when a ONESHOT pass completes.
wrap  out  1  one-cycle pulse when a CIRCULAR pass restarts.

Behaviour:
- Reset: ADDR_B=0, busy=0, done=0, wrap=0, internal count=0, state=IDLE. Reset overrides everything, including mid-run. No done pulse is generated by reset.
- Configuration (base, len, stride, mode) is latched on an accepted start. cfg_* changes during RUN have no effect.
- IDLE:
  - ADDR_B holds its last value. adv is ignored.
  - start=1 and abort=0: next cycle ADDR_B=cfg_base, cnt=len_eff-1, busy=1. Start-to-first-address latency is 1 cycle.
- RUN, per cycle, in priority order:
  - abort: go to IDLE next cycle. busy=0, ADDR_B held, no done or wrap.
  - adv with cnt==0:
    - ONESHOT: go to IDLE, done=1 for one cycle, ADDR_B held.
    - CIRCULAR: ADDR_B=base, cnt reloads, wrap=1 for one cycle, stay in RUN.
  - adv with cnt!=0: ADDR_B = (ADDR_B+stride) mod DEPTH. Computed at ADDR_W+1 bits; subtract DEPTH if the sum is >= DEPTH. cnt decrements.
  - No adv: all state holds.
- start during RUN is ignored. Mode, base, etc. cannot change mid-run without abort.
- done and wrap are registered and never high simultaneously with busy-entry from the same start.
- Back-to-back passes: start may be asserted in the cycle done is high, since the FSM is already in IDLE. The new first address appears the following cycle.
- len_eff=1: last is high from the first cycle. A single adv completes the pass.

Optional Feature:
R_BRAM_ADDR_RVALID_EN. When defined, adds outputs rd_valid (1) and rd_last (1). These are (busy && adv && !abort) and (last && adv && !abort), each delayed by RD_LAT registered stages so they align with BRAM dout. The pipeline is cleared by rst; abort does not flush reads already issued. When not defined, the ports and pipeline are absent and the remaining behaviour is identical.

Decomposition:
- package_fpga.v holds:
  - ADDR_WIDTH (existing).
  - Mode constants RB_MODE_ONESHOT=1'b0 and RB_MODE_CIRC=1'b1.
  - FSM state encodings RB_IDLE and RB_RUN.
- One natural sub-module, r_bram_addr_wrap_add: a combinational modulo-DEPTH adder (ADDR_W+1-bit sum, conditional subtract), reused by the write-side generator.
- The RVALID delay line stays inline.

Test Plan:
- Legacy mode: base=0, len=0, stride=1, CIRCULAR, start, then adv held high for 1030 cycles -> ADDR_B 0..511; wrap pulses on the cycles ADDR_B returns to 0 (twice); done never asserts.
- ONESHOT with stride: base=500, len=5, stride=7, DEPTH=512 -> ADDR_B sequence 500, 507, 2, 9, 16; last on 16; done one cycle after the 5th adv; busy falls; ADDR_B holds 16.
- Gapped adv: base=10, len=3, stride=1, adv toggled every other cycle -> each address held 2 cycles; done after the 3rd adv only.
- Abort: in RUN at ADDR_B=12, abort=adv=1 -> next cycle busy=0, ADDR_B=12, done=0; a subsequent start re-latches cfg.
- Reset mid-run: rst at cnt=3 -> next cycle ADDR_B=0, busy=0, done=0; start in IDLE together with abort is ignored.
- Edge cases: len=1 -> last high immediately, done after one adv. stride=0, len=4 -> ADDR_B constant for 4 advs. With R_BRAM_ADDR_RVALID_EN, RD_LAT=1: rd_valid lags adv by exactly 1 cycle.
